phys_reg_free_list: RTL and testbench
=====================================

Name: phys_reg_free_list

Overview:
- Circular free list of physical registers for the renaming front end.
- Decode/rename takes one free `MipsReg` per cycle for a new destination.
- Commit returns the previous mapping of a retired destination.
- One branch checkpoint of the head pointer allows single-cycle recovery on misprediction.

Parameters:
- DEPTH, 32, number of free-list slots; must be a power of two.
- FIRST_FREE, 32, physical register held in slot 0 at reset; slot i holds FIRST_FREE+i (p32..p63).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- alloc_req  in  1  rename requests one physical register this cycle.
- alloc_ready  out  1  list is non-empty; allocation will be granted.
- alloc_preg  out  6  `MipsReg` at head; valid whenever alloc_ready=1.
- release_valid  in  1  commit returns a register this cycle.
- release_preg  in  6  `MipsReg` being returned.
- ckpt_save  in  1  snapshot the head pointer (branch renamed).
- ckpt_restore  in  1  roll the head back to the snapshot (mispredict).
- ckpt_valid  out  1  a snapshot is held.
- free_count  out  6  number of free entries, 0..DEPTH.
- release_err  out  1  one-cycle pulse on an illegal release or illegal restore.

Behaviour:
- Storage and pointers:
  - Storage is mem[DEPTH] of `MipsReg`.
  - head and tail are log2(DEPTH)+1 bits wide (index plus wrap bit); ckpt_head has the same width.
  - free_count = tail - head, computed modulo 2^(log2(DEPTH)+1).
  - Full when free_count==DEPTH; empty when free_count==0.
- Reset (rst=1 at clk edge):
  - mem[i] = FIRST_FREE+i, head=0, tail=DEPTH (index 0, wrap 1).
  - free_count=32, alloc_ready=1, alloc_preg=p32.
  - ckpt_valid=0, release_err=0.
  - Reset mid-operation discards all state, including any pending checkpoint.
- Allocation:
  - alloc_preg = mem[head index], combinational (zero-latency peek).
  - Grant = alloc_req & alloc_ready & !ckpt_restore.
  - On grant, head increments at the edge.
  - alloc_req while empty is ignored and head is unchanged; the caller must stall on !alloc_ready.
- Release:
  - Accepted when release_valid & !full & release_preg != zero.
  - On accept: mem[tail index] <= release_preg, tail increments.
  - release_preg==zero is dropped silently; p0 is never renamed.
  - Release while full is dropped and release_err pulses for the following cycle.
- Checkpoint save:
  - ckpt_head <= head value before this cycle's allocation; ckpt_valid <= 1.
  - A new save overwrites the existing snapshot.
- Checkpoint restore:
  - Only when ckpt_valid: head <= ckpt_head, ckpt_valid <= 0.
  - Restore wins over alloc_req in the same cycle: no grant, alloc_ready unaffected.
  - Restore without ckpt_valid is ignored and release_err pulses.
  - Save and restore in the same cycle: restore executes, save is ignored.
- Simultaneous events:
  - Release and allocation in one cycle both proceed.
  - Release and restore in one cycle both proceed.
  - free_count reflects the combined effect next cycle.
  - No release-to-allocate bypass: with free_count==0, a same-cycle release does not satisfy alloc_req.
- Wrap-around: indices wrap modulo DEPTH; wrap bits disambiguate full from empty.
- Restore correctness relies on commit never releasing a register allocated after the checkpoint, which holds for in-order commit.

Decomposition:
- Reuse `mips_core_pkg::MipsReg` for all 6-bit register fields.
- Add to mips_core_pkg:
  - localparam NUM_PHYS_REGS=64.
  - localparam FREE_LIST_DEPTH=32.
  - typedef logic [5:0] FreeListPtr.
- No sub-module; a single flat module with one storage array and three pointer registers.

Test Plan:
- Reset, then alloc_req high for 32 cycles -> alloc_preg p32, p33 ... p63 in order; free_count falls 32->0; alloc_ready=0 after cycle 32; a 33rd alloc_req leaves head unchanged.
- Reset, allocate 3 (p32..p34), release p5 and p7 -> free_count=31; continue allocating through slot 31 -> after p63, alloc_preg=p5 then p7 (wrap-around).
- Reset, release p40 with list full -> dropped; release_err=1 for one cycle; free_count stays 32.
- Reset, allocate 2, ckpt_save, allocate 4 (free_count=26), ckpt_restore with alloc_req high -> no grant; next cycle alloc_preg=p34, free_count=30, ckpt_valid=0.
- free_count==0 with release_valid(p9) and alloc_req in same cycle -> no grant; next cycle alloc_ready=1, alloc_preg=p9, free_count=1.
- ckpt_restore with ckpt_valid=0 -> release_err pulses; head unchanged. Also release_preg=zero -> ignored, no error.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: architectural/physical register tags and free-list sizing.
package mips_core_pkg;

    localparam int NUM_PHYS_REGS   = 64;
    localparam int FREE_LIST_DEPTH = 32;

    typedef logic [5:0] MipsReg;
    typedef logic [5:0] FreeListPtr;

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical registers for rename, with a single head-pointer
// checkpoint for one-cycle branch-mispredict recovery.
module phys_reg_free_list
    import mips_core_pkg::*;
#(
    parameter int DEPTH      = FREE_LIST_DEPTH,
    parameter int FIRST_FREE = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alloc_req,
    output logic       alloc_ready,
    output MipsReg     alloc_preg,
    input  logic       release_valid,
    input  MipsReg     release_preg,
    input  logic       ckpt_save,
    input  logic       ckpt_restore,
    output logic       ckpt_valid,
    output FreeListPtr free_count,
    output logic       release_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    MipsReg           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] ckpt_head;
    logic [PTR_W-1:0] count;

    logic full;
    logic empty;
    logic grant;
    logic restore_ok;
    logic rel_accept;
    logic rel_nonzero;

    // Wrap bit makes tail - head unambiguous: DEPTH means full, 0 means empty.
    assign count       = tail - head;
    assign full        = (count == PTR_W'(DEPTH));
    assign empty       = (count == '0);
    assign free_count  = FreeListPtr'(count);

    assign alloc_ready = !empty;
    assign alloc_preg  = mem[head[IDX_W-1:0]];

    assign rel_nonzero = (release_preg != '0);
    assign grant       = alloc_req & alloc_ready & !ckpt_restore;
    assign restore_ok  = ckpt_restore & ckpt_valid;
    assign rel_accept  = release_valid & !full & rel_nonzero;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= MipsReg'(FIRST_FREE + i);
            end
            head        <= '0;
            tail        <= PTR_W'(DEPTH);
            ckpt_head   <= '0;
            ckpt_valid  <= 1'b0;
            release_err <= 1'b0;
        end else begin
            if (rel_accept) begin
                mem[tail[IDX_W-1:0]] <= release_preg;
                tail                 <= tail + 1'b1;
            end

            // Restore takes priority over both allocation and a same-cycle save.
            if (restore_ok) begin
                head       <= ckpt_head;
                ckpt_valid <= 1'b0;
            end else if (grant) begin
                head <= head + 1'b1;
            end

            if (ckpt_save && !ckpt_restore) begin
                ckpt_head  <= head;
                ckpt_valid <= 1'b1;
            end

            release_err <= (release_valid & full & rel_nonzero) |
                           (ckpt_restore & !ckpt_valid);
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: directed vectors push expected post-edge
// outputs; a monitor pops and compares one entry after every clock edge.
module tb_phys_reg_free_list;
    import mips_core_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic       alloc_ready;
    MipsReg     alloc_preg;
    logic       release_valid;
    MipsReg     release_preg;
    logic       ckpt_save;
    logic       ckpt_restore;
    logic       ckpt_valid;
    FreeListPtr free_count;
    logic       release_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string  tag;
        logic   rdy;
        MipsReg preg;
        int     cnt;
        logic   cv;
        logic   err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    phys_reg_free_list #(.DEPTH(32), .FIRST_FREE(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_ready  (alloc_ready),
        .alloc_preg   (alloc_preg),
        .release_valid(release_valid),
        .release_preg (release_preg),
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
        .ckpt_valid   (ckpt_valid),
        .free_count   (free_count),
        .release_err  (release_err)
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: after each edge the DUT presents new state; compare against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".alloc_ready"}, int'(alloc_ready), int'(e.rdy));
            chk({e.tag, ".free_count"},  int'(free_count),  e.cnt);
            chk({e.tag, ".ckpt_valid"},  int'(ckpt_valid),  int'(e.cv));
            chk({e.tag, ".release_err"}, int'(release_err), int'(e.err));
            if (e.rdy) chk({e.tag, ".alloc_preg"}, int'(alloc_preg), int'(e.preg));
        end
    end

    // Drive one cycle of inputs and record the outputs required after the coming edge.
    task automatic cyc(input string tag, input logic r, input logic req,
                       input logic rv, input int rp, input logic sv, input logic rs,
                       input logic x_rdy, input int x_preg, input int x_cnt,
                       input logic x_cv, input logic x_err);
        exp_t e;
        rst           = r;
        alloc_req     = req;
        release_valid = rv;
        release_preg  = MipsReg'(rp);
        ckpt_save     = sv;
        ckpt_restore  = rs;
        e.tag  = tag;
        e.rdy  = x_rdy;
        e.preg = MipsReg'(x_preg);
        e.cnt  = x_cnt;
        e.cv   = x_cv;
        e.err  = x_err;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; alloc_req = 1'b0; release_valid = 1'b0; release_preg = '0;
        ckpt_save = 1'b0; ckpt_restore = 1'b0;
        @(negedge clk);

        // Drain the whole list in order, then an ignored alloc and a release+alloc while empty.
        cyc("reset", 1, 0, 0, 0, 0, 0, 1, 32, 32, 0, 0);
        for (int i = 0; i < 32; i++)
            cyc("drain", 0, 1, 0, 0, 0, 0, (i < 31), 33 + i, 31 - i, 0, 0);
        cyc("empty_alloc", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("no_bypass", 0, 1, 1, 9, 0, 0, 1, 9, 1, 0, 0);

        // Wrap-around: returned registers appear after p63.
        cyc("reset2", 1, 0, 0, 0, 0, 0, 1, 32, 32, 0, 0);
        cyc("a1", 0, 1, 0, 0, 0, 0, 1, 33, 31, 0, 0);
        cyc("a2", 0, 1, 0, 0, 0, 0, 1, 34, 30, 0, 0);
        cyc("a3", 0, 1, 0, 0, 0, 0, 1, 35, 29, 0, 0);
        cyc("rel5", 0, 0, 1, 5, 0, 0, 1, 35, 30, 0, 0);
        cyc("rel7", 0, 0, 1, 7, 0, 0, 1, 35, 31, 0, 0);
        for (int k = 1; k <= 29; k++)
            cyc("wrap", 0, 1, 0, 0, 0, 0, 1, (k == 29) ? 5 : 35 + k, 31 - k, 0, 0);
        cyc("wrap_p7", 0, 1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
        cyc("wrap_end", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Release while full, then a zero release that must be silent.
        cyc("reset3", 1, 0, 0, 0, 0, 0, 1, 32, 32, 0, 0);
        cyc("rel_full", 0, 0, 1, 40, 0, 0, 1, 32, 32, 0, 1);
        cyc("err_clear", 0, 0, 0, 0, 0, 0, 1, 32, 32, 0, 0);
        cyc("rel_zero", 0, 0, 1, 0, 0, 0, 1, 32, 32, 0, 0);

        // Checkpoint save / restore, restore beating alloc, illegal restore.
        cyc("reset4", 1, 0, 0, 0, 0, 0, 1, 32, 32, 0, 0);
        cyc("c_a1", 0, 1, 0, 0, 0, 0, 1, 33, 31, 0, 0);
        cyc("c_a2", 0, 1, 0, 0, 0, 0, 1, 34, 30, 0, 0);
        cyc("save", 0, 0, 0, 0, 1, 0, 1, 34, 30, 1, 0);
        for (int k = 1; k <= 4; k++)
            cyc("c_post", 0, 1, 0, 0, 0, 0, 1, 34 + k, 30 - k, 1, 0);
        cyc("restore", 0, 1, 0, 0, 0, 1, 1, 34, 30, 0, 0);
        cyc("bad_restore", 0, 0, 0, 0, 0, 1, 1, 34, 30, 0, 1);
        cyc("bad_clear", 0, 0, 0, 0, 0, 0, 1, 34, 30, 0, 0);

        // Save captures the pre-allocation head when paired with an alloc.
        cyc("save_alloc", 0, 1, 0, 0, 1, 0, 1, 35, 29, 1, 0);
        cyc("s_a", 0, 1, 0, 0, 0, 0, 1, 36, 28, 1, 0);
        cyc("restore2", 0, 0, 1, 12, 1, 1, 1, 34, 31, 0, 0);

        // Reset discards a pending checkpoint.
        cyc("save3", 0, 0, 0, 0, 1, 0, 1, 34, 31, 1, 0);
        cyc("reset5", 1, 0, 0, 0, 0, 0, 1, 32, 32, 0, 0);

        rst = 1'b0; alloc_req = 1'b0; release_valid = 1'b0;
        ckpt_save = 1'b0; ckpt_restore = 1'b0;
        for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
